// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write FIFO feeding the data-memory write port.
//   Clk, Rst                      clock, async active-high reset
//   st_valid/st_op/st_addr/st_data  store request from MEM; st_ready = not full
//   ld_valid/ld_addr -> ld_hazard  load hits a pending or incoming store word
//   port_free -> dm_wr             head entry drained when the DM port is free
//   dm_op/dm_addr/dm_in32/16/8     head entry contents (zero when empty)
//   count                          occupied entries
//   err_misalign                   one-cycle pulse after an illegal store is dropped
module dm_store_buffer #(
   parameter int         DEPTH = 4,
   parameter int         PTRW  = $clog2(DEPTH),
   parameter logic [5:0] OP_SB = 6'b101000,
   parameter logic [5:0] OP_SH = 6'b101001,
   parameter logic [5:0] OP_SW = 6'b101011
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            st_valid,
   input  logic [5:0]      st_op,
   input  logic [11:0]     st_addr,
   input  logic [31:0]     st_data,
   output logic            st_ready,
   input  logic            ld_valid,
   input  logic [11:0]     ld_addr,
   output logic            ld_hazard,
   input  logic            port_free,
   output logic            dm_wr,
   output logic [5:0]      dm_op,
   output logic [11:0]     dm_addr,
   output logic [31:0]     dm_in32,
   output logic [15:0]     dm_in16,
   output logic [7:0]      dm_in8,
   output logic [PTRW:0]   count,
   output logic            err_misalign
);
   logic [5:0]       op_q   [DEPTH];
   logic [11:0]      addr_q [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] vld_q;
   logic [DEPTH-1:0] hit;
   logic [PTRW-1:0]  head, tail;
   logic             legal, push, pop, bad, empty;

   always_comb begin
      legal = (st_op == OP_SB) | ((st_op == OP_SH) & ~st_addr[0]) |
              ((st_op == OP_SW) & (st_addr[1:0] == 2'b00));
      empty = (count == '0);
      st_ready = (count != (PTRW+1)'(DEPTH));
      push = st_valid & st_ready & legal;
      bad = st_valid & st_ready & ~legal;
      pop = port_free & ~empty;
      dm_wr = pop;
      dm_op = empty ? '0 : op_q[head];
      dm_addr = empty ? '0 : addr_q[head];
      dm_in32 = empty ? '0 : data_q[head];
      dm_in16 = dm_in32[15:0];
      dm_in8 = dm_in32[7:0];
      // an entry popped this cycle still has its valid set, so it still hazards
      ld_hazard = ld_valid & ((|hit) | (push & (st_addr[11:2] == ld_addr[11:2])));
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_hit
      assign hit[i] = vld_q[i] & (addr_q[i][11:2] == ld_addr[11:2]);
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         vld_q <= '0;
         err_misalign <= 1'b0;
      end else begin
         err_misalign <= bad;
         if (pop) head <= head + 1'b1;
         if (push) tail <= tail + 1'b1;
         // push and pop never share an index: that needs empty (no pop) or full (no push)
         if (pop) vld_q[head] <= 1'b0;
         if (push) vld_q[tail] <= 1'b1;
         count <= (push & ~pop) ? count + 1'b1 : (~push & pop) ? count - 1'b1 : count;
      end
   end

   always_ff @(posedge Clk) begin
      if (push) begin
         op_q[tail] <= st_op;
         addr_q[tail] <= st_addr;
         data_q[tail] <= st_data;
      end
   end
endmodule

// File: tb/tb_dm_store_buffer.sv
// tb_dm_store_buffer: directed and random checks of dm_store_buffer against a queue model.
module tb_dm_store_buffer;
   localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;

   logic        Clk = 1'b0, Rst = 1'b1;
   logic        st_valid = 0, ld_valid = 0, port_free = 0;
   logic [5:0]  st_op = '0;
   logic [11:0] st_addr = '0, ld_addr = '0;
   logic [31:0] st_data = '0;
   logic        st_ready, ld_hazard, dm_wr, err_misalign;
   logic [5:0]  dm_op;
   logic [11:0] dm_addr;
   logic [31:0] dm_in32;
   logic [15:0] dm_in16;
   logic [7:0]  dm_in8;
   logic [2:0]  count;

   typedef struct packed {logic [5:0] op; logic [11:0] a; logic [31:0] d;} ent_t;
   ent_t q[$];
   bit   exp_err = 0;
   int   n_vec = 0, n_bad = 0;

   dm_store_buffer dut (
      .Clk(Clk), .Rst(Rst), .st_valid(st_valid), .st_op(st_op), .st_addr(st_addr),
      .st_data(st_data), .st_ready(st_ready), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_hazard(ld_hazard), .port_free(port_free), .dm_wr(dm_wr), .dm_op(dm_op),
      .dm_addr(dm_addr), .dm_in32(dm_in32), .dm_in16(dm_in16), .dm_in8(dm_in8),
      .count(count), .err_misalign(err_misalign)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op, input logic [11:0] a);
      return op == SB || (op == SH && a % 2 == 0) || (op == SW && a % 4 == 0);
   endfunction

   // one cycle: drive at posedge+1, check at negedge, advance model, return at next posedge+1
   task automatic step(input bit sv, input logic [5:0] op, input logic [11:0] a, input logic [31:0] d,
                       input bit lv, input logic [11:0] la, input bit pf);
      bit rdy, wr, lg, hz;
      ent_t h;
      st_valid = sv; st_op = op; st_addr = a; st_data = d;
      ld_valid = lv; ld_addr = la; port_free = pf;
      @(negedge Clk);
      rdy = q.size() < 4;
      wr = pf && q.size() > 0;
      lg = sv && rdy && is_legal(op, a);
      h = q.size() > 0 ? q[0] : '0;
      hz = 0;
      foreach (q[k]) if (q[k].a / 4 == la / 4) hz = 1;
      if (lg && a / 4 == la / 4) hz = 1;
      hz = hz && lv;
      chk("st_ready", st_ready, rdy);
      chk("dm_wr", dm_wr, wr);
      chk("count", count, q.size());
      chk("dm_op", dm_op, h.op);
      chk("dm_addr", dm_addr, h.a);
      chk("dm_in32", dm_in32, h.d);
      chk("dm_in16", dm_in16, h.d & 32'hFFFF);
      chk("dm_in8", dm_in8, h.d & 32'hFF);
      chk("ld_hazard", ld_hazard, hz);
      chk("err_misalign", err_misalign, exp_err);
      if (wr) void'(q.pop_front());
      if (lg) q.push_back('{op, a, d});
      exp_err = sv && rdy && !lg;
      @(posedge Clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst st_ready", st_ready, 1);
      chk("rst dm_wr", dm_wr, 0);
      chk("rst count", count, 0);
      chk("rst ld_hazard", ld_hazard, 0);
      chk("rst err", err_misalign, 0);
      @(negedge Clk);
      Rst = 0;
      @(posedge Clk);
      #1;
      // single sw posted then drained
      step(1, SW, 12'h010, 32'hDEADBEEF, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      // fill to full, 5th held, then drain in order
      for (int i = 0; i < 4; i++) step(1, SW, 12'(4 * i), 32'h1000 + i, 0, 0, 0);
      step(1, SW, 12'h040, 32'h5555, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
      // word-granular load hazard
      step(1, SB, 12'h013, 32'hAA, 0, 0, 0);
      step(0, 0, 0, 0, 1, 12'h010, 0);
      step(0, 0, 0, 0, 1, 12'h014, 0);
      step(0, 0, 0, 0, 1, 12'h010, 1);
      step(0, 0, 0, 0, 1, 12'h010, 0);
      step(1, SW, 12'h020, 32'h1234, 1, 12'h022, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      // misaligned stores dropped
      step(1, SH, 12'h011, 32'h1, 0, 0, 0);
      step(1, SW, 12'h012, 32'h2, 0, 0, 0);
      step(1, 6'h3F, 12'h000, 32'h3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      // reset mid-drain
      for (int i = 0; i < 3; i++) step(1, SW, 12'(8 * i), 32'hC0 + i, 0, 0, 0);
      st_valid = 0; ld_valid = 0; port_free = 1;
      #2;
      chk("pre-rst dm_wr", dm_wr, 1);
      Rst = 1;
      #1;
      chk("mid rst dm_wr", dm_wr, 0);
      chk("mid rst count", count, 0);
      chk("mid rst st_ready", st_ready, 1);
      @(posedge Clk);
      #1;
      chk("held rst dm_wr", dm_wr, 0);
      @(negedge Clk);
      Rst = 0;
      q.delete();
      exp_err = 0;
      @(posedge Clk);
      #1;
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [5:0] op;
         case ($urandom_range(0, 5))
            0, 1:    op = SB;
            2:       op = SH;
            3, 4:    op = SW;
            default: op = 6'($urandom);
         endcase
         step($urandom_range(0, 2) != 0, op, 12'($urandom_range(0, 47)), $urandom,
              $urandom_range(0, 1) == 1, 12'($urandom_range(0, 47)), $urandom_range(0, 2) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
